// File: rtl/latch_bank_write_arbiter.sv
// Two-requester write arbiter for a bank of transparent D latches: SETUP/OPEN/HOLD/DONE sequencing.
// Optional macro LATCH_ARB_FIXED_PRIO_EN: requester 0 always wins ties (default is round-robin).
module latch_bank_write_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned OPEN_CYC  = 2,
  parameter int unsigned HOLD_CYC  = 1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] latch_d,
  output logic [DEPTH-1:0] latch_en,
  output logic             busy,
  output logic             owner,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_OPEN  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int unsigned MAX_AB = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
  localparam int unsigned MAXC   = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int unsigned CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [WIDTH-1:0]   latch_d_q, latch_d_d;
  logic               owner_q, owner_d;
  logic [DEPTH-1:0]   latch_en_q, latch_en_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic               busy_q, busy_d;
  logic               grant;

  // Tie-break: the requester that was not served last wins, unless fixed priority is built in.
`ifdef LATCH_ARB_FIXED_PRIO_EN
  assign grant = req0 ? 1'b0 : 1'b1;
`else
  assign grant = (req0 && req1) ? ~owner_q : req1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      latch_d_q  <= '0;
      owner_q    <= 1'b1;
      latch_en_q <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      latch_d_q  <= latch_d_d;
      owner_q    <= owner_d;
      latch_en_q <= latch_en_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    latch_d_d = latch_d_q;
    owner_d   = owner_q;
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d   = S_SETUP;
          cnt_d     = '0;
          owner_d   = grant;
          addr_d    = grant ? addr1 : addr0;
          latch_d_d = grant ? data1 : data0;
        end
      end
      S_SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          state_d = S_OPEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OPEN: begin
        if (cnt_q == CW'(OPEN_CYC - 1)) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    latch_en_d = '0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    busy_d     = (state_d != S_IDLE);
    if (state_d == S_OPEN) latch_en_d = DEPTH'(1) << addr_d;
    if (state_d == S_DONE) begin
      done0_d = ~owner_d;
      done1_d = owner_d;
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign latch_d   = latch_d_q;
  assign latch_en  = latch_en_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Randomized and directed bench for latch_bank_write_arbiter against a transaction-timeline model.
// Honours LATCH_ARB_FIXED_PRIO_EN the same way as the design.
module tb_latch_bank_write_arbiter;
  localparam int W = 8;
  localparam int D = 4;
  localparam int S = 1;
  localparam int O = 2;
  localparam int H = 1;
  localparam int DONE_T = S + O + H;
  localparam int TOTAL  = DONE_T + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [1:0]   addr0 = '0, addr1 = '0;
  logic [W-1:0] data0 = '0, data1 = '0;
  logic         done0, done1, busy, owner;
  logic [W-1:0] latch_d;
  logic [D-1:0] latch_en;
  logic [2:0]   dbg_state;

  int n_vec = 0;
  int n_fail = 0;

  // Model: m_t is cycles since grant (-1 when idle).
  int           m_t = -1;
  logic         m_owner = 1'b1;
  logic [1:0]   m_addr = '0;
  logic [W-1:0] m_d = '0;
  logic [W-1:0] exp_q[$];

  latch_bank_write_arbiter #(
    .WIDTH(W), .DEPTH(D), .SETUP_CYC(S), .OPEN_CYC(O), .HOLD_CYC(H)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1),
    .done0(done0), .done1(done1),
    .latch_d(latch_d), .latch_en(latch_en),
    .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    logic g;
    if (rst) begin
      m_t = -1; m_owner = 1'b1; m_d = '0; m_addr = '0;
    end else if (m_t < 0) begin
      if (req0 || req1) begin
`ifdef LATCH_ARB_FIXED_PRIO_EN
        g = req0 ? 1'b0 : 1'b1;
`else
        g = (req0 && req1) ? !m_owner : req1;
`endif
        m_owner = g;
        m_addr  = g ? addr1 : addr0;
        m_d     = g ? data1 : data0;
        exp_q.push_back(m_d);
        m_t = 0;
      end
    end else begin
      m_t++;
      if (m_t == TOTAL) m_t = -1;
    end
  endtask

  task automatic check_outputs();
    logic [D-1:0] e_en;
    e_en = (m_t >= S && m_t < S + O) ? D'(1) << m_addr : '0;
    check("latch_d", 32'(latch_d), 32'(m_d));
    check("latch_en", 32'(latch_en), 32'(e_en));
    check("done0", 32'(done0), 32'(m_t == DONE_T && !m_owner));
    check("done1", 32'(done1), 32'(m_t == DONE_T && m_owner));
    check("busy", 32'(busy), 32'(m_t >= 0));
    check("owner", 32'(owner), 32'(m_owner));
    check("en_onehot", 32'($countones(latch_en) <= 1), 32'd1);
    check("done_mutex", 32'(done0 && done1), 32'd0);
    if (m_t == DONE_T) begin
      if (exp_q.size() == 0) check("exp_queue", 32'd0, 32'd1);
      else check("done_data", 32'(latch_d), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic step_until_t(input int t, input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (m_t == t) begin hit = 1; break; end
    end
    if (!hit) check("phase_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_until_done(input int budget, output int who);
    who = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (m_t == DONE_T) begin
        who = int'(m_owner);
        if (m_owner) req1 = 1'b0; else req0 = 1'b0;
        break;
      end
    end
    if (who < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int who;
    @(negedge clk);
    // Reset and idle
    do_reset(2);
    check("rst_owner", 32'(owner), 32'd1);
    check("rst_latch_d", 32'(latch_d), 32'd0);
    for (int i = 0; i < 10; i++) step();
    check("idle_busy", 32'(busy), 32'd0);

    // Single write
    req0 = 1'b1; addr0 = 2'd2; data0 = 8'hA5;
    step_until_t(S, 10);
    check("single_en", 32'(latch_en), 32'h4);
    check("single_d", 32'(latch_d), 32'hA5);
    run_until_done(20, who);
    check("single_who", 32'(who), 32'd0);
    step();

    // Mid-transaction changes
    req0 = 1'b1; addr0 = 2'd2; data0 = 8'hA5;
    step_until_t(S, 10);
    data0 = 8'hFF; addr0 = 2'd3; req0 = 1'b0;
    step();
    check("mid_en", 32'(latch_en), 32'h4);
    check("mid_d", 32'(latch_d), 32'hA5);
    run_until_done(20, who);
    check("mid_who", 32'(who), 32'd0);
    step();

    // Reset during OPEN
    req0 = 1'b1; addr0 = 2'd1; data0 = 8'h3C;
    step_until_t(S, 10);
    check("rst_open_en", 32'(latch_en), 32'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("rst_open_busy", 32'(busy), 32'd0);
    check("rst_open_d", 32'(latch_d), 32'd0);
    check("rst_open_en0", 32'(latch_en), 32'd0);
    run_until_done(20, who);
    check("after_rst_who", 32'(who), 32'd0);
    step();

    // Contention after reset
    do_reset(2);
    req0 = 1'b1; addr0 = 2'd0; data0 = 8'h11;
    req1 = 1'b1; addr1 = 2'd3; data1 = 8'h22;
    for (int g = 0; g < 4; g++) begin
      run_until_done(20, who);
`ifdef LATCH_ARB_FIXED_PRIO_EN
      check("grant_order", 32'(who), 32'd0);
`else
      check("grant_order", 32'(who), 32'(g % 2));
`endif
      step();
      if (who == 0) req0 = 1'b1; else req1 = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < TOTAL + 1; i++) step();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (m_t != DONE_T) begin
        if (!req0 && $urandom_range(0, 3) == 0) begin
          req0 = 1'b1; addr0 = 2'($urandom); data0 = W'($urandom);
        end else if (req0 && $urandom_range(0, 5) == 0) begin
          addr0 = 2'($urandom); data0 = W'($urandom);
          if (m_t >= 0 && !m_owner && $urandom_range(0, 2) == 0) req0 = 1'b0;
        end
        if (!req1 && $urandom_range(0, 3) == 0) begin
          req1 = 1'b1; addr1 = 2'($urandom); data1 = W'($urandom);
        end else if (req1 && $urandom_range(0, 5) == 0) begin
          addr1 = 2'($urandom); data1 = W'($urandom);
          if (m_t >= 0 && m_owner && $urandom_range(0, 2) == 0) req1 = 1'b0;
        end
      end
      step();
      if (rst) exp_q.delete();
      if (m_t == DONE_T) begin
        if (m_owner) req1 = 1'b0; else req0 = 1'b0;
      end
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < TOTAL + 1; i++) step();
    check("final_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/latch_bank_write_arbiter.md
# latch_bank_write_arbiter

Controller that shares a bank of DEPTH transparent D latches (each with a D input and an active-high `en`) between two write requesters. It arbitrates the requests and drives a common latch data bus plus one-hot latch enables with a fixed setup / open / hold sequence, so D is never changed while any enable is high. It sits between the requesting logic and the latch bank and is the only driver of the bank's D and `en` inputs.

## Interface
- `WIDTH`, 8, data width of each latch word
- `DEPTH`, 4, number of latch words; power of two, ≥2; `AW = $clog2(DEPTH)`
- `SETUP_CYC`, 1, cycles D is stable before enable opens (≥1)
- `OPEN_CYC`, 2, cycles enable is held high (≥1)
- `HOLD_CYC`, 1, cycles D is held after enable closes (≥1)

- Clock and reset: one clock, `clk`; reset is synchronous and active-high, named `rst`.
- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  synchronous active-high reset
- `req0` / `req1`  in  1  write request from requester 0 / 1; level, held until that requester's `done`
- `addr0` / `addr1`  in  AW  target latch index for requester 0 / 1
- `data0` / `data1`  in  WIDTH  write data for requester 0 / 1
- `done0` / `done1`  out  1  one-cycle pulse; the requester's write has completed
- `latch_d`  out  WIDTH  shared D bus to all latches
- `latch_en`  out  DEPTH  one-hot enables, bit i drives latch i
- `busy`  out  1  high in every state except IDLE
- `owner`  out  1  index of the requester served by the current or last transaction

## Operation
- All outputs are registered. Reset values: `latch_d=0`, `latch_en=0`, `done0=done1=0`, `busy=0`, `owner=1`, so requester 0 wins the first tie. State resets to IDLE and counter to 0.
- FSM states: IDLE → SETUP → OPEN → HOLD → DONE → IDLE.
- IDLE: `req0`/`req1` are sampled only here. If any is high, the controller:
  - grants one requester;
  - captures that requester's addr/data into internal registers and drives `latch_d` from them;
  - sets `owner`;
  - moves to SETUP.
  - If no request is high, it stays in IDLE.
- Arbitration:
  - A single request is granted.
  - If both are high, the requester ≠ `owner` wins (round-robin).
- SETUP: `latch_en=0`, `latch_d` = captured data. Lasts SETUP_CYC cycles.
- OPEN: `latch_en` = one-hot of the captured addr, `latch_d` unchanged. Lasts OPEN_CYC cycles.
- HOLD: `latch_en=0`, `latch_d` unchanged. Lasts HOLD_CYC cycles.
- DONE: one cycle with `done[owner]=1`, `latch_en=0`, `latch_d` unchanged. Then IDLE.
- `latch_d` changes only on the IDLE→SETUP transition. It holds its value in IDLE and is never reset except by `rst`.
- Input changes outside IDLE are ignored:
  - addr/data/req changes, including a req dropped mid-transaction, do not affect the transaction in progress;
  - the transaction always completes, and `done` still pulses.
- A requester must deassert req on the edge that ends its DONE cycle. A req still high in IDLE is treated as a new request.
- `rst` asserted in any state: on the next edge every output goes to its reset value and the state goes to IDLE. A transaction interrupted this way produces no `done` pulse.

## Timing
- Request high at rising edge k while in IDLE:
  - SETUP is occupied from edge k to k+SETUP_CYC;
  - `latch_en` is high for exactly OPEN_CYC cycles starting at edge k+SETUP_CYC;
  - `done` is high for exactly one cycle starting at edge k+SETUP_CYC+OPEN_CYC+HOLD_CYC.
- Transaction length is SETUP_CYC+OPEN_CYC+HOLD_CYC+1 cycles (5 by default), plus at least one IDLE cycle between grants. Back-to-back throughput is one write per 6 cycles at defaults.
- Every enable pulse is preceded by at least SETUP_CYC and followed by at least HOLD_CYC cycles of stable `latch_d`.
- At most one `latch_en` bit is high in any cycle. `done0` and `done1` are never high together.

## Configuration
- `LATCH_ARB_FIXED_PRIO_EN`:
  - Defined: requester 0 always wins when both requests are high; `owner` is still updated for observation.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then idle: with `rst` high for 2 cycles, all outputs are 0 and `owner=1`. After release with no requests, `busy` stays 0 for 10 cycles.
- Single write: `req0=1`, `addr0=2`, `data0=8'hA5` at edge k:
  - `latch_d=8'hA5` from k;
  - `latch_en=4'b0100` for the cycles starting at k+1 and k+2;
  - `done0` high for the cycle starting at k+4;
  - `done1` never high.
- Contention: both requesters pending after reset, `addr0=0`/`data0=8'h11`, `addr1=3`/`data1=8'h22`:
  - requester 0 is served first (`latch_en=4'b0001`);
  - after it drops req, requester 1 is served next (`latch_en=4'b1000`, `latch_d=8'h22`);
  - with `req0` re-raised, the grants keep alternating 0,1,0,1.
- Mid-transaction changes: during OPEN, change `data0` to 8'hFF and drop `req0`:
  - `latch_d` stays 8'hA5;
  - the enable pulse remains exactly 2 cycles;
  - `done0` still pulses.
- Reset during OPEN: assert `rst` while `latch_en=4'b0010`:
  - next edge `latch_en=0`, `busy=0`, `latch_d=0`;
  - no `done` pulse;
  - a new request afterwards completes normally.
- With `LATCH_ARB_FIXED_PRIO_EN` defined, both requests held high continuously: every grant goes to requester 0 and `done1` never pulses.
